// File: rtl/me_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : me_seq                                                     |
// | Description : Operand loader / result collector for a byte-serial       |
// |               modular-exponentiation engine. Holds the x, y and m        |
// |               operands, issues a one-cycle start pulse, collects NB      |
// |               result bytes (LSB first) and aborts on a cycle timeout.    |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               cfg_wr/cfg_sel/cfg_addr/cfg_wdata - 32-bit operand writes  |
// |               go - start request; busy/done/err - status                 |
// |               rd_addr -> rd_data - registered result word read           |
// |               me_start, me_x/me_y/me_m - engine request side             |
// |               me_result, me_valid - engine byte stream                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module me_seq #(
    parameter int K       = 2048,
    parameter int TIMEOUT = 1 << 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_wr,
    input  logic [1:0]                cfg_sel,
    input  logic [$clog2(K/32)-1:0]   cfg_addr,
    input  logic [31:0]               cfg_wdata,
    input  logic                      go,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic [$clog2(K/32)-1:0]   rd_addr,
    output logic [31:0]               rd_data,
    output logic                      me_start,
    output logic [K-1:0]              me_x,
    output logic [K-1:0]              me_y,
    output logic [K-1:0]              me_m,
    input  logic [7:0]                me_result,
    input  logic                      me_valid
);

    localparam int c_WORDS = K / 32;
    localparam int c_NB    = K / 8;
    localparam int c_CW    = $clog2(c_NB);
    localparam int c_TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_CW-1:0] c_LAST_BYTE = c_CW'(c_NB - 1);
    localparam logic [c_TW-1:0] c_TLAST     = c_TW'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_WAIT    = 3'd2;
    localparam logic [2:0] c_COLLECT = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic [c_TW-1:0] r_tcnt;
    logic            r_err;
    logic [K-1:0]    r_x;
    logic [K-1:0]    r_y;
    logic [K-1:0]    r_m;
    logic [K-1:0]    r_result;
    logic [31:0]     r_rd_data;

    logic w_collecting;
    logic w_last;
    logic w_expire;
    logic w_launch;
    logic w_cfg_ok;

    assign w_collecting = (r_state == c_WAIT) || (r_state == c_COLLECT);
    assign w_last       = w_collecting && me_valid && (r_cnt == c_LAST_BYTE);
    // A final byte landing on the timeout cycle completes normally.
    assign w_expire     = w_collecting && (r_tcnt == c_TLAST) && !w_last;
    assign w_launch     = (r_state == c_IDLE) && go;
    // Writes in the launch cycle are still accepted, so operands settle
    // before me_start is seen by the engine.
    assign w_cfg_ok     = cfg_wr && (cfg_sel != 2'd3) && (r_state == c_IDLE) &&
                          (int'(cfg_addr) < c_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (go) w_next = c_START;
            c_START:   w_next = c_WAIT;
            c_WAIT: begin
                if (w_last || w_expire) w_next = c_DONE;
                else if (me_valid)      w_next = c_COLLECT;
            end
            c_COLLECT: if (w_last || w_expire) w_next = c_DONE;
            c_DONE:    w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_err     <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_m       <= '0;
            r_result  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_cfg_ok) begin
                case (cfg_sel)
                    2'd0:    r_x[32*cfg_addr +: 32] <= cfg_wdata;
                    2'd1:    r_y[32*cfg_addr +: 32] <= cfg_wdata;
                    2'd2:    r_m[32*cfg_addr +: 32] <= cfg_wdata;
                    default: ;
                endcase
            end

            if (w_launch) begin
                r_cnt  <= '0;
                r_tcnt <= '0;
                r_err  <= 1'b0;
            end else if (w_collecting) begin
                r_tcnt <= r_tcnt + 1'b1;
                if (me_valid) begin
                    r_result[8*r_cnt +: 8] <= me_result;
                    r_cnt                  <= r_cnt + 1'b1;
                end
                if (w_expire) begin
                    r_err <= 1'b1;
                end
            end

            r_rd_data <= (int'(rd_addr) < c_WORDS) ? r_result[32*rd_addr +: 32] : 32'd0;
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);
    assign me_start = (r_state == c_START);
    assign err      = r_err;
    assign rd_data  = r_rd_data;
    assign me_x     = r_x;
    assign me_y     = r_y;
    assign me_m     = r_m;

endmodule
`default_nettype wire

// File: tb/tb_me_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_me_seq                                                  |
// | Description : Self-checking bench for me_seq (K=64, TIMEOUT=100).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_me_seq;

    localparam int K       = 64;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_sel;
    logic [0:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        go;
    logic        busy;
    logic        done;
    logic        err;
    logic [0:0]  rd_addr;
    logic [31:0] rd_data;
    logic        me_start;
    logic [K-1:0] me_x;
    logic [K-1:0] me_y;
    logic [K-1:0] me_m;
    logic [7:0]  me_result;
    logic        me_valid;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: operands as word arrays, result as a byte array.
    logic [31:0] mx[2];
    logic [31:0] my[2];
    logic [31:0] mm[2];
    logic [7:0]  mres[8];

    typedef struct {
        logic [1:0]  sel;
        logic [0:0]  addr;
        logic [31:0] wdata;
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] em;
    } vec_t;

    vec_t tbl[9];

    me_seq #(.K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .go        (go),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .me_start  (me_start),
        .me_x      (me_x),
        .me_y      (me_y),
        .me_m      (me_m),
        .me_result (me_result),
        .me_valid  (me_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_write(input logic [1:0] sel, input logic [0:0] a, input logic [31:0] d);
        if (sel == 2'd0) mx[a] = d;
        else if (sel == 2'd1) my[a] = d;
        else if (sel == 2'd2) mm[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mx[i] = '0; my[i] = '0; mm[i] = '0;
        end
        for (int i = 0; i < 8; i++) mres[i] = '0;
    endtask

    task automatic check_ops();
        check("me_x", me_x, {mx[1], mx[0]});
        check("me_y", me_y, {my[1], my[0]});
        check("me_m", me_m, {mm[1], mm[0]});
    endtask

    task automatic check_result();
        for (int a = 0; a < 2; a++) begin
            rd_addr = 1'(a);
            tick();
            check("rd_data", {32'd0, rd_data},
                  {32'd0, mres[4*a+3], mres[4*a+2], mres[4*a+1], mres[4*a]});
        end
    endtask

    // Raise go (optionally with a same-cycle operand write); checks the
    // START cycle and returns sampled in the first WAIT cycle.
    task automatic start_op(input bit wr, input logic [1:0] sel, input logic [0:0] a,
                            input logic [31:0] d);
        go = 1'b1;
        if (wr) begin
            cfg_wr = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_wdata = d;
        end
        tick();
        go = 1'b0;
        cfg_wr = 1'b0;
        if (wr) model_write(sel, a, d);
        check("me_start_pulse", me_start, 1);
        check("busy_start", busy, 1);
        check_ops();
        tick();
        check("me_start_once", me_start, 0);
        check("busy_wait", busy, 1);
        check("err_cleared", err, 0);
    endtask

    // Deliver nb bytes (nb<8 ends in timeout); t counts edges since WAIT entry.
    task automatic op(input logic [7:0] b[8], input int nb, input int gmin, input int gmax,
                      input bit poke);
        int t;
        int g;
        t = 0;
        if (poke) begin
            cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_addr = 1'b0; cfg_wdata = ~mx[0]; go = 1'b1;
            tick(); t++;
            cfg_wr = 1'b0; go = 1'b0;
            check("busy_no_restart", me_start, 0);
            check_ops();
        end
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin
                g = int'($urandom_range(gmax, gmin));
                repeat (g) begin
                    tick(); t++;
                    check("done_in_gap", done, 0);
                end
            end
            me_valid = 1'b1; me_result = b[i];
            tick(); t++;
            me_valid = 1'b0; me_result = 8'($urandom);
            mres[i] = b[i];
            check("done_on_byte", done, (nb == 8 && i == 7));
        end
        if (nb < 8) begin
            while (t < TIMEOUT) begin
                tick(); t++;
                check("done_timeout", done, (t == TIMEOUT));
            end
            check("err_timeout", err, 1);
        end else begin
            check("err_ok", err, 0);
        end
        tick();
        check("busy_after", busy, 0);
        check("done_once", done, 0);
        check("err_sticky", err, (nb < 8));
        check_ops();
        check_result();
    endtask

    initial begin
        logic [7:0] b1[8];
        logic [7:0] b2[8];
        logic [7:0] rb[8];
        int nw;
        int nb;

        b1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        b2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        tbl[0] = '{2'd0, 1'b0, 32'h0000_0010, 64'h10, 64'h0, 64'h0};
        tbl[1] = '{2'd0, 1'b1, 32'hCAFE_F00D, 64'hCAFEF00D_00000010, 64'h0, 64'h0};
        tbl[2] = '{2'd0, 1'b1, 32'h0000_0000, 64'h10, 64'h0, 64'h0};
        tbl[3] = '{2'd1, 1'b0, 32'h0000_0081, 64'h10, 64'h81, 64'h0};
        tbl[4] = '{2'd1, 1'b1, 32'h0000_0000, 64'h10, 64'h81, 64'h0};
        tbl[5] = '{2'd2, 1'b0, 32'h0000_00E1, 64'h10, 64'h81, 64'hE1};
        tbl[6] = '{2'd2, 1'b1, 32'h0000_0000, 64'h10, 64'h81, 64'hE1};
        tbl[7] = '{2'd3, 1'b0, 32'hDEAD_BEEF, 64'h10, 64'h81, 64'hE1};
        tbl[8] = '{2'd3, 1'b1, 32'h1234_5678, 64'h10, 64'h81, 64'hE1};

        rst_n = 1'b1; cfg_wr = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        go = 1'b0; rd_addr = '0; me_result = '0; me_valid = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_me_start", me_start, 0);
        check("rst_rd_data", rd_data, 0);
        check_ops();
        rst_n = 1'b1;
        tick();

        // Table-driven operand writes, including reserved select.
        for (int i = 0; i < 9; i++) begin
            cfg_wr = 1'b1; cfg_sel = tbl[i].sel; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
            tick();
            cfg_wr = 1'b0;
            model_write(tbl[i].sel, tbl[i].addr, tbl[i].wdata);
            check("tbl_x", me_x, tbl[i].ex);
            check("tbl_y", me_y, tbl[i].ey);
            check("tbl_m", me_m, tbl[i].em);
        end

        // Contiguous bytes.
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        op(b1, 8, 0, 0, 1'b0);
        check("word0", rd_data, 32'h0807_0605);

        // Three-cycle gaps between bytes; fresh data first so stale results show.
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        op(b2, 8, 0, 0, 1'b0);
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        op(b1, 8, 3, 3, 1'b0);
        rd_addr = 1'b0;
        tick();
        check("gap_word0", rd_data, 32'h0403_0201);

        // Write + go while busy must be ignored.
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        op(b2, 8, 0, 2, 1'b1);

        // Timeout with no bytes, partial result retained, then recovery.
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        op(b1, 0, 0, 0, 1'b0);
        start_op(1'b1, 2'd1, 1'b1, 32'h0BAD_CAFE);
        op(b1, 8, 0, 1, 1'b0);

        // Randomized operations against the model.
        for (int it = 0; it < 24; it++) begin
            nw = int'($urandom_range(4, 0));
            for (int w = 0; w < nw; w++) begin
                cfg_wr = 1'b1; cfg_sel = 2'($urandom); cfg_addr = 1'($urandom);
                cfg_wdata = $urandom;
                me_valid = 1'($urandom); me_result = 8'($urandom);
                tick();
                cfg_wr = 1'b0; me_valid = 1'b0;
                model_write(cfg_sel, cfg_addr, cfg_wdata);
                check_ops();
            end
            check_result();
            for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
            nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 8;
            start_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom);
            op(rb, nb, 0, 3, 1'($urandom));
        end

        // Reset during COLLECT after three bytes.
        start_op(1'b0, 2'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            me_valid = 1'b1; me_result = 8'hA1 + 8'(i);
            tick();
        end
        me_valid = 1'b0;
        check("collect_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_me_start", me_start, 0);
        check("arst_rd_data", rd_data, 0);
        check_ops();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            me_valid = 1'b1; me_result = 8'h5A;
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_done", done, 0);
        end
        me_valid = 1'b0;
        check_result();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
